pc_reg: RTL and testbench
=========================

// Module: pc_reg
// PURPOSE
//   Program-counter state register for the instruction-fetch stage.
//   Captures the next-PC value on every rising clock edge and drives the current PC
//   to instruction memory and the PC+4 adder.
//   Asynchronous active-low reset forces the PC to the reset vector.
// PARAMETERS
//   WIDTH         32            PC width in bits
//   RESET_VECTOR  32'h0000_0000 value loaded by reset; must fit in WIDTH bits
// PORTS
//   clk    input   1      clock, rising-edge active
//   rstn   input   1      reset, asynchronous, active-low
//   pc     input   WIDTH  next-PC value to capture
//   pcOut  output  WIDTH  current PC, registered
//   stall  input   1      hold PC when 1 (only with PC_REG_STALL_EN)
//   Declaration order is fixed as pcOut, pc, clk, rstn (stall last).
//   Existing instantiations connect these ports positionally.
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low (rstn).
//   - Reset: rstn=0 forces pcOut=RESET_VECTOR immediately, without waiting for clk.
//     pcOut holds that value for as long as rstn=0; clk edges and pc changes are ignored.
//   - Normal operation: at each posedge clk with rstn=1, pcOut <= pc.
//     Latency is one cycle. There is no handshake.
//   - Reset release: when rstn rises between edges, the first posedge clk with rstn=1
//     loads pc. If rstn and clk rise simultaneously, reset wins for that edge.
//   - Reset asserted mid-operation overrides any pending load.
//   - Data path: pc is stored bit-exact (no masking, no alignment correction, no arithmetic).
//     All WIDTH bits are stored, including bits [1:0]. Values wrap only as presented on pc.
//   - pcOut never changes except on posedge clk or on rstn falling or low.
//   - pcOut is driven directly from flops, with no combinational path from pc.
// CONFIGURATION
//   - Macro PC_REG_STALL_EN, when defined:
//       adds the stall port;
//       stall=1 at a posedge clk keeps pcOut unchanged (clock-enable);
//       reset still overrides stall.
//   - When undefined: the stall port does not exist and the register loads every cycle.
// STRUCTURE
//   - Shared package pc_pkg: PC_WIDTH=32, PC_RESET_VECTOR=32'h0, and typedef pc_t (logic [31:0]).
//     These are the defaults for WIDTH and RESET_VECTOR.
//   - One sub-module, dff_ar_en: parameterised D flop with async active-low reset value and
//     clock enable.
//     pc_reg instantiates it once, with enable tied to 1 or to ~stall.
// TESTING
//   - rstn=0 at t=10ns, clk period 50ns, pc=0 then pc=4 at 110ns, rstn held 0 ->
//     pcOut=0 for the whole run.
//   - rstn=0 then 1, pc=4 before the next posedge -> pcOut=4 after that edge, not before.
//   - Sequence pc=4,8,12 on successive edges with rstn=1 -> pcOut=4,8,12, each one edge late.
//   - pcOut=32'h0000_0040, then rstn falls mid-cycle -> pcOut=0 at once, before any clk edge.
//   - RESET_VECTOR=32'hBFC0_0000 -> during reset pcOut=32'hBFC0_0000.
//     pc=32'hFFFF_FFFF -> pcOut=32'hFFFF_FFFF after the edge.
//   - PC_REG_STALL_EN defined, pcOut=8, stall=1, pc=12 -> pcOut stays 8.
//     stall=0 -> pcOut=12 after the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter definitions for the instruction-fetch stage.
// Provides the default PC width, the default reset vector and the PC type.
package pc_pkg;

    localparam int           PC_WIDTH        = 32;
    localparam logic [31:0]  PC_RESET_VECTOR = 32'h0000_0000;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage : pc_pkg

// File: rtl/pc_reg_dff_ar_en.sv
// dff_ar_en: parameterised D flip-flop bank with an asynchronous active-low
// reset to a fixed value and a synchronous clock enable.
module dff_ar_en #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Async reset to RESET_VAL; otherwise capture i_d on enabled rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values;
            // a blocking '=' here would create order-dependent simulation races.
            r_q <= i_d;
        end
    end

    // Output comes straight from the flops: no combinational path from i_d.
    assign o_q = r_q;

endmodule : dff_ar_en

// File: rtl/pc_reg.sv
// pc_reg: program-counter state register for the instruction-fetch stage.
// Captures the next-PC on each rising clk edge and drives the current PC to
// instruction memory and the PC+4 adder. rstn (async, active-low) forces the
// PC to RESET_VECTOR immediately. The value is stored bit-exact.
// Optional feature: define PC_REG_STALL_EN to add a 'stall' port that holds
// the PC (clock enable); reset still overrides stall.
// Port order is fixed (pcOut, pc, clk, rstn[, stall]) because existing
// instantiations connect positionally.
module pc_reg
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    output logic [WIDTH-1:0] pcOut,
    input  logic [WIDTH-1:0] pc,
    input  logic             clk,
    input  logic             rstn
`ifdef PC_REG_STALL_EN
    ,
    input  logic             stall
`endif
);

    logic w_en;

    // Load enable: every cycle by default, or gated off while stalled.
`ifdef PC_REG_STALL_EN
    assign w_en = ~stall;
`else
    assign w_en = 1'b1;
`endif

    dff_ar_en #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VECTOR)
    ) u_pc_ff (
        .clk   (clk),
        .rst_n (rstn),
        .i_en  (w_en),
        .i_d   (pc),
        .o_q   (pcOut)
    );

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed scenarios plus random traffic.
// Two instances share the stimulus: one with the default reset vector, one
// with RESET_VECTOR = 32'hBFC0_0000. Expected values come from a behavioural
// model and are queued; a monitor pops and compares on every clk rise and on
// every rstn fall.
module tb_pc_reg;
    import pc_pkg::*;

    localparam pc_t RV_A = 32'h0000_0000;
    localparam pc_t RV_B = 32'hBFC0_0000;

    typedef struct {
        string name;
        pc_t   exp_a;
        pc_t   exp_b;
    } sb_item_t;

    logic clk;
    logic rstn;
    pc_t  pc_in;
    pc_t  pc_out_a;
    pc_t  pc_out_b;
`ifdef PC_REG_STALL_EN
    logic stall;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    sb_item_t sb[$];

    // Model state: the PC each instance should currently be holding.
    pc_t cur_a;
    pc_t cur_b;

    pc_reg #(.WIDTH(32), .RESET_VECTOR(RV_A)) dut_a (
        .pcOut (pc_out_a),
        .pc    (pc_in),
        .clk   (clk),
        .rstn  (rstn)
`ifdef PC_REG_STALL_EN
        ,
        .stall (stall)
`endif
    );

    pc_reg #(.WIDTH(32), .RESET_VECTOR(RV_B)) dut_b (
        .pcOut (pc_out_b),
        .pc    (pc_in),
        .clk   (clk),
        .rstn  (rstn)
`ifdef PC_REG_STALL_EN
        ,
        .stall (stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    task automatic check(input string nm, input pc_t got, input pc_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a new output on each clk rise or rstn fall.
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            #1;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow got=empty expected=entry at %0t", $time);
                end else begin
                    sb_item_t it;
                    it = sb.pop_front();
                    check({it.name, "_a"}, pc_out_a, it.exp_a);
                    check({it.name, "_b"}, pc_out_b, it.exp_b);
                end
            end
        end
    end

    // One cycle of stimulus, applied mid-cycle (after a falling clk edge).
    task automatic step(input logic r, input pc_t p, input logic s,
                        input int dly, input string nm);
        logic s_eff;
        @(negedge clk);
        if (dly > 0) #(dly);
`ifdef PC_REG_STALL_EN
        s_eff = s;
        stall = s;
`else
        s_eff = 1'b0;
        if (s) s_eff = 1'b0;
`endif
        if (!r && rstn) begin
            // Reset falls mid-cycle: output must change at once.
            cur_a = RV_A;
            cur_b = RV_B;
            sb.push_back('{name: {nm, "_async"}, exp_a: cur_a, exp_b: cur_b});
        end
        rstn  = r;
        pc_in = p;
        #5;
        // Between edges the output must not follow pc or a rising rstn.
        check({nm, "_hold_a"}, pc_out_a, cur_a);
        check({nm, "_hold_b"}, pc_out_b, cur_b);
        if (!r) begin
            cur_a = RV_A;
            cur_b = RV_B;
        end else if (!s_eff) begin
            cur_a = p;
            cur_b = p;
        end
        sb.push_back('{name: {nm, "_edge"}, exp_a: cur_a, exp_b: cur_b});
    endtask

    initial begin
        rstn  = 1'b1;
        pc_in = '0;
`ifdef PC_REG_STALL_EN
        stall = 1'b0;
`endif
        // Reset asserted at 10 ns, before the first clk edge.
        #10;
        mon_en = 1'b1;
        cur_a  = RV_A;
        cur_b  = RV_B;
        sb.push_back('{name: "por_async", exp_a: cur_a, exp_b: cur_b});
        rstn = 1'b0;
        sb.push_back('{name: "por_edge", exp_a: cur_a, exp_b: cur_b});

        // Reset held: pc changes (including pc=4 at 110 ns) are ignored.
        step(1'b0, 32'd0, 1'b0, 0,  "rst_hold0");
        step(1'b0, 32'd4, 1'b0, 10, "rst_hold4");
        step(1'b0, 32'd4, 1'b0, 0,  "rst_hold4b");

        // Release, pc=4 before the next edge: visible only after it.
        step(1'b1, 32'd4,  1'b0, 0, "rel_4");
        step(1'b1, 32'd8,  1'b0, 0, "seq_8");
        step(1'b1, 32'd12, 1'b0, 0, "seq_12");

        // pcOut=0x40, then reset falls mid-cycle.
        step(1'b1, 32'h40, 1'b0, 0, "load_40");
        step(1'b0, 32'h44, 1'b0, 0, "midrst");
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 0, "rel_ffff");
        step(1'b1, 32'h0000_0003, 1'b0, 0, "lsb_bits");

`ifdef PC_REG_STALL_EN
        step(1'b1, 32'd8,  1'b0, 0, "pre_stall8");
        step(1'b1, 32'd12, 1'b1, 0, "stall_hold");
        step(1'b1, 32'd12, 1'b0, 0, "stall_release");
        step(1'b0, 32'd16, 1'b1, 0, "stall_vs_rst");
        step(1'b1, 32'd20, 1'b1, 0, "stall_after_rst");
`endif

        // Random traffic: occasional resets, random PCs, random stalls.
        for (int i = 0; i < 200; i++) begin
            logic r;
            logic s;
            r = ($urandom_range(0, 19) != 0);
            s = ($urandom_range(0, 3) == 0);
            step(r, pc_t'($urandom), s, 0, $sformatf("rnd%0d", i));
        end

        // Drain the final edge and confirm every expectation was consumed.
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d expected=0 entries left", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "time limit exceeded");
    end

endmodule : tb_pc_reg
